gshare_pht_ctrl: RTL and testbench
==================================

Name: gshare_pht_ctrl

Overview:
- Controller and initiator for the single-port 256x2 gshare PHT SRAM macro.
- Accepts predict lookups from fetch and counter updates from commit, and arbitrates them onto the one RW port.
- Performs the read-modify-write of the 2-bit saturating counters and maintains the committed global history register (GHR).
- After reset, sweeps the whole array to weakly-not-taken, because the SRAM has no reset.

Parameters:
- INDEX_WIDTH, 8, PHT index width; array depth = 2**INDEX_WIDTH.
- PC_LSB, 2, lowest PC bit used in the index.
- STARVE_LIMIT, 4, consecutive lost arbitrations before a pending update takes priority.
- INIT_VAL, 2'b01, counter value written during the init sweep.

Ports:
- clk  in  1  core clock; also drives the SRAM clk0.
- rst_n  in  1  asynchronous active-low reset.
- pred_valid  in  1  predict request.
- pred_pc  in  32  fetch PC.
- pred_ready  out  1  predict accepted this cycle.
- pred_resp_valid  out  1  prediction result valid.
- pred_taken  out  1  counter MSB.
- pred_resp_index  out  INDEX_WIDTH  index used; pipeline returns it on update.
- upd_valid  in  1  update request.
- upd_index  in  INDEX_WIDTH  index to update.
- upd_taken  in  1  resolved direction.
- upd_ready  out  1  update accepted this cycle.
- ghr  out  INDEX_WIDTH  committed history.
- init_done  out  1  init sweep complete.
- sram_csb  out  1  active-low chip select.
- sram_web  out  1  active-low write enable.
- sram_addr  out  INDEX_WIDTH  SRAM address.
- sram_din  out  2  SRAM write data.
- sram_dout  in  2  SRAM read data.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: state=INIT, init_cnt=0, ghr=0, init_done=0, pred_resp_valid=0, starve_cnt=0.
  - While rst_n is low: sram_csb=1; pred_ready=0 and upd_ready=0.
- SRAM timing:
  - The SRAM registers csb/web/addr/din at posedge.
  - Read data is valid on sram_dout for the whole following cycle.
  - A write issued in cycle N commits at the end of cycle N+1.
  - A read issued in N+1 or later sees the new value, so no forwarding is required.
- SRAM port outputs are combinational from state and inputs. sram_csb=1 whenever no access is issued.
- State INIT:
  - Each cycle: csb=0, web=0, addr=init_cnt, din=INIT_VAL; init_cnt++.
  - After addr 2**INDEX_WIDTH-1, go to IDLE and set init_done=1. Duration is exactly 256 cycles at the default.
  - pred_ready=0 and upd_ready=0 throughout.
- State IDLE, arbitration:
  - Update wins if upd_valid and (!pred_valid or starve_cnt==STARVE_LIMIT). Otherwise predict wins if pred_valid.
  - starve_cnt increments when upd_valid is high and the update loses; it clears when the update is accepted.
- Predict accept (pred_ready=1):
  - index = pred_pc[PC_LSB +: INDEX_WIDTH] ^ ghr; issue a read (csb=0, web=1).
  - Next cycle: pred_resp_valid=1, pred_taken=sram_dout[1], pred_resp_index=registered index.
  - Back-to-back predicts give one response per cycle.
- Update accept (upd_ready=1):
  - Issue a read of upd_index; latch the index and taken flag.
  - Shift ghr: ghr <= {ghr[INDEX_WIDTH-2:0], upd_taken}.
  - Go to UPD_WR.
- State UPD_WR:
  - new = taken ? sat_inc(sram_dout) : sat_dec(sram_dout). Saturate at 2'b11 and 2'b00.
  - Issue the write (csb=0, web=0, addr=latched index, din=new).
  - pred_ready=0 and upd_ready=0; return to IDLE.
- pred_resp_valid=0 in any cycle not following an accepted predict.
- Boundaries:
  - Back-to-back updates to the same index must read the freshly written value; there is one IDLE cycle between them by construction.
  - ghr wraps by shift; there is no speculative history.
  - Reset asserted mid-UPD_WR or mid-INIT abandons the operation; the sweep restarts from 0 after release.
  - A stale registered SRAM write re-committing after reset is benign because the sweep overwrites it.

Decomposition:
- Shared package gshare_pkg holds:
  - INDEX_WIDTH and INIT_VAL constants.
  - The counter enum: SNT=00, WNT=01, WT=10, ST=11.
  - The state enum: INIT, IDLE, UPD_WR.
- Sub-module gshare_sat_ctr: combinational 2-bit saturating inc/dec.
- The SRAM macro is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Reset release, then idle 256 cycles -> exactly 256 writes of 2'b01 to addr 0..255 in order; init_done rises on cycle 256; every later predict gives pred_taken=0.
- ghr=0, predict pc=0x0000_0040 -> sram_addr=0x10; next cycle pred_resp_valid=1, pred_resp_index=0x10, pred_taken=0.
- Two updates, index 0x10, taken=1 -> writes 2'b10 then 2'b11; third taken update writes 2'b11 (saturated); ghr=0x07. Then predict with index 0x10 -> pred_taken=1.
- Three not-taken updates on a WNT entry -> writes 00, 00, 00 (saturation).
- pred_valid and upd_valid held high continuously -> 4 predicts accepted, then 1 update (read + UPD_WR), pattern repeats; no update lost.
- rst_n pulsed low during UPD_WR -> sram_csb=1 while in reset; INIT restarts at addr 0; ghr=0; the pending update is not written after release.

Source files
------------

// File: rtl/gshare_pkg.sv
// Shared constants and enums for the gshare pattern history table controller.
package gshare_pkg;

    localparam int         PHT_INDEX_WIDTH = 8;
    localparam logic [1:0] PHT_INIT_VAL    = 2'b01;

    // 2-bit saturating direction counter; the MSB is the predicted direction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPD_WR
    } state_e;

endpackage

// File: rtl/gshare_sat_ctr.sv
// Combinational 2-bit saturating counter step toward the resolved direction.
module gshare_sat_ctr
    import gshare_pkg::*;
(
    input  logic [1:0] ctr_in,
    input  logic       taken,
    output logic [1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        case (ctr_e'(ctr_in))
            SNT:     ctr_out = taken ? WNT : SNT;
            WNT:     ctr_out = taken ? WT  : SNT;
            WT:      ctr_out = taken ? ST  : WNT;
            ST:      ctr_out = taken ? ST  : WT;
            default: ctr_out = ctr_in;
        endcase
    end

endmodule

// File: rtl/gshare_pht_ctrl.sv
// Gshare PHT controller: clears the SRAM after reset, then arbitrates fetch
// predicts and commit-time read-modify-write updates onto the single RW port.
module gshare_pht_ctrl
    import gshare_pkg::*;
#(
    parameter int         INDEX_WIDTH  = PHT_INDEX_WIDTH,
    parameter int         PC_LSB       = 2,
    parameter int         STARVE_LIMIT = 4,
    parameter logic [1:0] INIT_VAL     = PHT_INIT_VAL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pred_valid,
    input  logic [31:0]            pred_pc,
    output logic                   pred_ready,
    output logic                   pred_resp_valid,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_resp_index,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic                   upd_taken,
    output logic                   upd_ready,
    output logic [INDEX_WIDTH-1:0] ghr,
    output logic                   init_done,
    output logic                   sram_csb,
    output logic                   sram_web,
    output logic [INDEX_WIDTH-1:0] sram_addr,
    output logic [1:0]             sram_din,
    input  logic [1:0]             sram_dout
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    state_e                 state;
    state_e                 next_state;
    logic [INDEX_WIDTH-1:0] init_cnt;
    logic [STARVE_W-1:0]    starve_cnt;
    logic [INDEX_WIDTH-1:0] upd_idx_q;
    logic                   upd_taken_q;
    logic [INDEX_WIDTH-1:0] pred_idx;
    logic [1:0]             ctr_next;
    logic                   upd_win;
    logic                   pred_win;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^pred_pc;
    assign pred_idx       = pred_pc[PC_LSB +: INDEX_WIDTH] ^ ghr;

    // An update only beats a concurrent predict once it has lost STARVE_LIMIT times in a row
    assign upd_win  = (state == IDLE) && upd_valid &&
                      (!pred_valid || (starve_cnt == STARVE_W'(STARVE_LIMIT)));
    assign pred_win = (state == IDLE) && pred_valid && !upd_win;

    assign pred_taken = pred_resp_valid & sram_dout[1];

    gshare_sat_ctr u_sat_ctr (
        .ctr_in  (sram_dout),
        .taken   (upd_taken_q),
        .ctr_out (ctr_next)
    );

    always_comb begin
        next_state = state;
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_addr  = '0;
        sram_din   = '0;
        pred_ready = 1'b0;
        upd_ready  = 1'b0;
        case (state)
            INIT: begin
                sram_csb  = 1'b0;
                sram_web  = 1'b0;
                sram_addr = init_cnt;
                sram_din  = INIT_VAL;
                if (init_cnt == '1) next_state = IDLE;
            end
            IDLE: begin
                if (upd_win) begin
                    upd_ready  = 1'b1;
                    sram_csb   = 1'b0;
                    sram_addr  = upd_index;
                    next_state = UPD_WR;
                end else if (pred_win) begin
                    pred_ready = 1'b1;
                    sram_csb   = 1'b0;
                    sram_addr  = pred_idx;
                end
            end
            UPD_WR: begin
                sram_csb   = 1'b0;
                sram_web   = 1'b0;
                sram_addr  = upd_idx_q;
                sram_din   = ctr_next;
                next_state = IDLE;
            end
            default: next_state = INIT;
        endcase
        // The state register already reads INIT in reset, so the port must be muted explicitly
        if (!rst_n) begin
            sram_csb   = 1'b1;
            pred_ready = 1'b0;
            upd_ready  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= INIT;
            init_cnt        <= '0;
            ghr             <= '0;
            init_done       <= 1'b0;
            pred_resp_valid <= 1'b0;
            pred_resp_index <= '0;
            starve_cnt      <= '0;
            upd_idx_q       <= '0;
            upd_taken_q     <= 1'b0;
        end else begin
            state           <= next_state;
            pred_resp_valid <= pred_ready;
            if (pred_ready) pred_resp_index <= pred_idx;
            if (state == INIT) begin
                init_cnt <= init_cnt + INDEX_WIDTH'(1);
                if (init_cnt == '1) init_done <= 1'b1;
            end
            if (upd_ready) begin
                ghr         <= {ghr[INDEX_WIDTH-2:0], upd_taken};
                upd_idx_q   <= upd_index;
                upd_taken_q <= upd_taken;
                starve_cnt  <= '0;
            end else if ((state == IDLE) && upd_valid && (starve_cnt < STARVE_W'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Randomized self-checking bench for gshare_pht_ctrl with a behavioural SRAM and PHT model.
module tb_gshare_pht_ctrl;

    localparam int IW     = 8;
    localparam int DEPTH  = 256;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic          pred_ready;
    logic          pred_resp_valid;
    logic          pred_taken;
    logic [IW-1:0] pred_resp_index;
    logic          upd_valid;
    logic [IW-1:0] upd_index;
    logic          upd_taken;
    logic          upd_ready;
    logic [IW-1:0] ghr;
    logic          init_done;
    logic          sram_csb;
    logic          sram_web;
    logic [IW-1:0] sram_addr;
    logic [1:0]    sram_din;
    logic [1:0]    sram_dout;

    logic [1:0]    mem [DEPTH];
    int            ref_pht [DEPTH];
    int            ref_ghr;
    int            n_checks;
    int            n_errors;

    always #5 clk = ~clk;

    gshare_pht_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pred_valid      (pred_valid),
        .pred_pc         (pred_pc),
        .pred_ready      (pred_ready),
        .pred_resp_valid (pred_resp_valid),
        .pred_taken      (pred_taken),
        .pred_resp_index (pred_resp_index),
        .upd_valid       (upd_valid),
        .upd_index       (upd_index),
        .upd_taken       (upd_taken),
        .upd_ready       (upd_ready),
        .ghr             (ghr),
        .init_done       (init_done),
        .sram_csb        (sram_csb),
        .sram_web        (sram_web),
        .sram_addr       (sram_addr),
        .sram_din        (sram_din),
        .sram_dout       (sram_dout)
    );

    // Single-port SRAM: registered access, read data held until the next read
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (sram_web) sram_dout <= mem[sram_addr];
            else          mem[sram_addr] <= sram_din;
        end
    end

    function automatic int pc_index(input logic [31:0] pc, input int g);
        return int'((pc >> 2) & 32'hFF) ^ g;
    endfunction

    function automatic int next_ctr(input int c, input bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_pht[i] = 1;
        ref_ghr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pred_valid = 1'b1; upd_valid = 1'b1;
        pred_pc = $urandom; upd_index = IW'($urandom); upd_taken = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (sram_csb !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_csb: got %0b expected 1", sram_csb); end
        n_checks++; if (pred_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_pred_ready: got %0b expected 0", pred_ready); end
        n_checks++; if (upd_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_upd_ready: got %0b expected 0", upd_ready); end
        n_checks++; if (init_done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_init_done: got %0b expected 0", init_done); end
        n_checks++; if (ghr !== '0) begin n_errors++; $display("[TB] FAIL reset_ghr: got %0h expected 0", ghr); end
        n_checks++; if (pred_resp_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_resp_valid: got %0b expected 0", pred_resp_valid); end
    endtask

    task automatic test_init_sweep();
        int bad_mem;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_checks++; if (sram_csb !== 1'b0 || sram_web !== 1'b0) begin n_errors++; $display("[TB] FAIL init_write[%0d]: got csb=%0b web=%0b expected 0/0", i, sram_csb, sram_web); end
            n_checks++; if (sram_addr !== IW'(i)) begin n_errors++; $display("[TB] FAIL init_addr: got %0h expected %0h", sram_addr, i); end
            n_checks++; if (sram_din !== 2'b01) begin n_errors++; $display("[TB] FAIL init_din[%0d]: got %0b expected 01", i, sram_din); end
            n_checks++; if (pred_ready !== 1'b0 || upd_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL init_ready[%0d]: got %0b/%0b expected 0/0", i, pred_ready, upd_ready); end
            n_checks++; if (init_done !== 1'b0) begin n_errors++; $display("[TB] FAIL init_done_early[%0d]: got %0b expected 0", i, init_done); end
            @(negedge clk);
        end
        pred_valid = 1'b0; upd_valid = 1'b0;
        #1;
        n_checks++; if (init_done !== 1'b1) begin n_errors++; $display("[TB] FAIL init_done: got %0b expected 1", init_done); end
        bad_mem = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 2'b01) bad_mem++;
        n_checks++; if (bad_mem != 0) begin n_errors++; $display("[TB] FAIL init_contents: got %0d bad entries expected 0", bad_mem); end
        model_reset();
    endtask

    task automatic test_predict_basic();
        int exp_idx;
        int exp_taken;
        @(negedge clk);
        pred_pc = 32'h0000_0040; pred_valid = 1'b1;
        #1;
        n_checks++; if (pred_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL pred_ready: got %0b expected 1", pred_ready); end
        n_checks++; if (sram_csb !== 1'b0 || sram_web !== 1'b1) begin n_errors++; $display("[TB] FAIL pred_read: got csb=%0b web=%0b expected 0/1", sram_csb, sram_web); end
        n_checks++; if (sram_addr !== IW'(pc_index(pred_pc, ref_ghr))) begin n_errors++; $display("[TB] FAIL pred_addr: got %0h expected %0h", sram_addr, pc_index(pred_pc, ref_ghr)); end
        exp_idx = pc_index(pred_pc, ref_ghr);
        exp_taken = (ref_pht[exp_idx] >= 2) ? 1 : 0;
        // Back-to-back random predicts, each response checked the following cycle
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) begin pred_pc = $urandom; pred_valid = 1'b1; end
            else pred_valid = 1'b0;
            #1;
            n_checks++; if (pred_resp_valid !== 1'b1) begin n_errors++; $display("[TB] FAIL pred_resp_valid[%0d]: got %0b expected 1", k, pred_resp_valid); end
            n_checks++; if (pred_resp_index !== IW'(exp_idx)) begin n_errors++; $display("[TB] FAIL pred_resp_index[%0d]: got %0h expected %0h", k, pred_resp_index, exp_idx); end
            n_checks++; if (pred_taken !== 1'(exp_taken)) begin n_errors++; $display("[TB] FAIL pred_taken[%0d]: got %0b expected %0d", k, pred_taken, exp_taken); end
            exp_idx = pc_index(pred_pc, ref_ghr);
            exp_taken = (ref_pht[exp_idx] >= 2) ? 1 : 0;
        end
        @(negedge clk); #1;
        n_checks++; if (pred_resp_valid !== 1'b0) begin n_errors++; $display("[TB] FAIL pred_resp_idle: got %0b expected 0", pred_resp_valid); end
    endtask

    task automatic run_updates(input string name, input int idx, input bit t, input int count);
        int exp_new;
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            upd_valid = 1'b1; upd_index = IW'(idx); upd_taken = t;
            #1;
            n_checks++; if (upd_ready !== 1'b1 || sram_addr !== IW'(idx) || sram_web !== 1'b1) begin n_errors++; $display("[TB] FAIL %s_accept[%0d]: got rdy=%0b addr=%0h web=%0b expected 1/%0h/1", name, k, upd_ready, sram_addr, sram_web, idx); end
            exp_new = next_ctr(ref_pht[idx], t);
            ref_pht[idx] = exp_new;
            ref_ghr = ((ref_ghr << 1) | int'(t)) & 8'hFF;
            @(negedge clk);
            upd_valid = 1'b0;
            #1;
            n_checks++; if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_addr !== IW'(idx)) begin n_errors++; $display("[TB] FAIL %s_wr[%0d]: got csb=%0b web=%0b addr=%0h expected 0/0/%0h", name, k, sram_csb, sram_web, sram_addr, idx); end
            n_checks++; if (sram_din !== 2'(exp_new)) begin n_errors++; $display("[TB] FAIL %s_din[%0d]: got %0b expected %0d", name, k, sram_din, exp_new); end
            n_checks++; if (upd_ready !== 1'b0 || pred_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL %s_wr_ready[%0d]: got %0b/%0b expected 0/0", name, k, upd_ready, pred_ready); end
        end
    endtask

    task automatic test_update_saturate();
        run_updates("upd_taken", 'h10, 1'b1, 3);
        n_checks++; if (ghr !== IW'(ref_ghr)) begin n_errors++; $display("[TB] FAIL upd_ghr: got %0h expected %0h", ghr, ref_ghr); end
        @(negedge clk);
        pred_pc = 32'h0000_005C; pred_valid = 1'b1;
        #1;
        n_checks++; if (sram_addr !== IW'(pc_index(pred_pc, ref_ghr))) begin n_errors++; $display("[TB] FAIL upd_pred_addr: got %0h expected %0h", sram_addr, pc_index(pred_pc, ref_ghr)); end
        @(negedge clk);
        pred_valid = 1'b0;
        #1;
        n_checks++; if (pred_taken !== ((ref_pht[pc_index(32'h5C, ref_ghr)] >= 2) ? 1'b1 : 1'b0)) begin n_errors++; $display("[TB] FAIL upd_pred_taken: got %0b expected taken", pred_taken); end
    endtask

    task automatic test_not_taken();
        int idx;
        idx = $urandom_range(0, DEPTH - 1);
        while (ref_pht[idx] != 1) idx = $urandom_range(0, DEPTH - 1);
        run_updates("upd_not_taken", idx, 1'b0, 3);
        n_checks++; if (ghr !== IW'(ref_ghr)) begin n_errors++; $display("[TB] FAIL nt_ghr: got %0h expected %0h", ghr, ref_ghr); end
    endtask

    task automatic test_back_to_back();
        int idx, exp_idx, exp_new, exp_taken, phase;
        bit t, pending;
        idx = $urandom_range(0, DEPTH - 1);
        t = 1'($urandom);
        pending = 1'b0; exp_idx = 0; exp_taken = 0; exp_new = 0;
        @(negedge clk);
        pred_valid = 1'b1; upd_valid = 1'b1;
        pred_pc = $urandom; upd_index = IW'(idx); upd_taken = t;
        for (int c = 0; c < 18; c++) begin
            #1;
            phase = c % 6;
            n_checks++; if (pred_resp_valid !== pending) begin n_errors++; $display("[TB] FAIL b2b_resp_valid[%0d]: got %0b expected %0b", c, pred_resp_valid, pending); end
            if (pending) begin
                n_checks++; if (pred_resp_index !== IW'(exp_idx) || pred_taken !== 1'(exp_taken)) begin n_errors++; $display("[TB] FAIL b2b_resp[%0d]: got idx=%0h taken=%0b expected %0h/%0d", c, pred_resp_index, pred_taken, exp_idx, exp_taken); end
            end
            pending = 1'b0;
            if (phase < 4) begin
                n_checks++; if (pred_ready !== 1'b1 || upd_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL b2b_pred_win[%0d]: got pred=%0b upd=%0b expected 1/0", c, pred_ready, upd_ready); end
                pending = 1'b1;
                exp_idx = pc_index(pred_pc, ref_ghr);
                exp_taken = (ref_pht[exp_idx] >= 2) ? 1 : 0;
            end else if (phase == 4) begin
                n_checks++; if (upd_ready !== 1'b1 || pred_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL b2b_upd_win[%0d]: got pred=%0b upd=%0b expected 0/1", c, pred_ready, upd_ready); end
                exp_new = next_ctr(ref_pht[idx], t);
                ref_pht[idx] = exp_new;
                ref_ghr = ((ref_ghr << 1) | int'(t)) & 8'hFF;
            end else begin
                n_checks++; if (pred_ready !== 1'b0 || upd_ready !== 1'b0 || sram_web !== 1'b0 || sram_din !== 2'(exp_new)) begin n_errors++; $display("[TB] FAIL b2b_wr[%0d]: got rdy=%0b/%0b web=%0b din=%0b expected 0/0/0/%0d", c, pred_ready, upd_ready, sram_web, sram_din, exp_new); end
            end
            @(negedge clk);
        end
        pred_valid = 1'b0; upd_valid = 1'b0;
    endtask

    task automatic test_random_traffic();
        int losses, exp_idx, exp_taken, exp_new, idx;
        bit busy, pending, uwin, t;
        losses = 0; busy = 1'b0; pending = 1'b0;
        exp_idx = 0; exp_taken = 0; exp_new = 0; idx = 0; t = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            pred_valid = ($urandom_range(0, 99) < 60);
            upd_valid  = ($urandom_range(0, 99) < 40);
            pred_pc    = $urandom;
            upd_index  = IW'($urandom);
            upd_taken  = 1'($urandom);
            #1;
            n_checks++; if (pred_resp_valid !== pending) begin n_errors++; $display("[TB] FAIL rnd_resp_valid[%0d]: got %0b expected %0b", c, pred_resp_valid, pending); end
            if (pending) begin
                n_checks++; if (pred_resp_index !== IW'(exp_idx) || pred_taken !== 1'(exp_taken)) begin n_errors++; $display("[TB] FAIL rnd_resp[%0d]: got idx=%0h taken=%0b expected %0h/%0d", c, pred_resp_index, pred_taken, exp_idx, exp_taken); end
            end
            pending = 1'b0;
            if (busy) begin
                n_checks++; if (pred_ready !== 1'b0 || upd_ready !== 1'b0 || sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_addr !== IW'(idx) || sram_din !== 2'(exp_new)) begin n_errors++; $display("[TB] FAIL rnd_wr[%0d]: got rdy=%0b/%0b csb=%0b web=%0b addr=%0h din=%0b expected 0/0/0/0/%0h/%0d", c, pred_ready, upd_ready, sram_csb, sram_web, sram_addr, sram_din, idx, exp_new); end
                busy = 1'b0;
            end else begin
                uwin = upd_valid && (!pred_valid || losses == STARVE);
                n_checks++; if (upd_ready !== uwin || pred_ready !== (pred_valid && !uwin)) begin n_errors++; $display("[TB] FAIL rnd_arb[%0d]: got pred=%0b upd=%0b expected %0b/%0b", c, pred_ready, upd_ready, pred_valid && !uwin, uwin); end
                if (uwin) begin
                    idx = int'(upd_index); t = upd_taken;
                    n_checks++; if (sram_addr !== upd_index || sram_web !== 1'b1 || sram_csb !== 1'b0) begin n_errors++; $display("[TB] FAIL rnd_upd_rd[%0d]: got addr=%0h web=%0b expected %0h/1", c, sram_addr, sram_web, idx); end
                    exp_new = next_ctr(ref_pht[idx], t);
                    ref_pht[idx] = exp_new;
                    ref_ghr = ((ref_ghr << 1) | int'(t)) & 8'hFF;
                    losses = 0; busy = 1'b1;
                end else if (pred_valid) begin
                    exp_idx = pc_index(pred_pc, ref_ghr);
                    exp_taken = (ref_pht[exp_idx] >= 2) ? 1 : 0;
                    n_checks++; if (sram_addr !== IW'(exp_idx) || sram_web !== 1'b1 || sram_csb !== 1'b0) begin n_errors++; $display("[TB] FAIL rnd_pred_rd[%0d]: got addr=%0h web=%0b expected %0h/1", c, sram_addr, sram_web, exp_idx); end
                    pending = 1'b1;
                    if (upd_valid) losses++;
                end else begin
                    n_checks++; if (sram_csb !== 1'b1) begin n_errors++; $display("[TB] FAIL rnd_idle_csb[%0d]: got %0b expected 1", c, sram_csb); end
                end
            end
            n_checks++; if (ghr !== IW'(ref_ghr) && !busy) begin n_errors++; $display("[TB] FAIL rnd_ghr[%0d]: got %0h expected %0h", c, ghr, ref_ghr); end
        end
        @(negedge clk);
        pred_valid = 1'b0; upd_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_update();
        int idx, bad, bad_mem;
        idx = $urandom_range(0, DEPTH - 1);
        while (ref_pht[idx] == 0) idx = $urandom_range(0, DEPTH - 1);
        @(negedge clk);
        upd_valid = 1'b1; upd_index = IW'(idx); upd_taken = 1'b1;
        #1;
        n_checks++; if (upd_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL rst_mid_accept: got %0b expected 1", upd_ready); end
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        n_checks++; if (sram_web !== 1'b0 || sram_csb !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_mid_in_wr: got csb=%0b web=%0b expected 0/0", sram_csb, sram_web); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sram_csb !== 1'b1) begin n_errors++; $display("[TB] FAIL rst_mid_csb: got %0b expected 1", sram_csb); end
        n_checks++; if (upd_ready !== 1'b0 || pred_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_mid_ready: got %0b/%0b expected 0/0", pred_ready, upd_ready); end
        n_checks++; if (ghr !== '0 || init_done !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_mid_regs: got ghr=%0h done=%0b expected 0/0", ghr, init_done); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_addr !== IW'(i) || sram_din !== 2'b01) bad++;
            @(negedge clk);
        end
        #1;
        n_checks++; if (bad != 0) begin n_errors++; $display("[TB] FAIL rst_mid_sweep: got %0d bad sweep cycles expected 0", bad); end
        n_checks++; if (init_done !== 1'b1) begin n_errors++; $display("[TB] FAIL rst_mid_init_done: got %0b expected 1", init_done); end
        bad_mem = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== 2'b01) bad_mem++;
        n_checks++; if (bad_mem != 0 || mem[idx] !== 2'b01) begin n_errors++; $display("[TB] FAIL rst_mid_contents: got %0d bad entries, entry %0h=%0b expected 0 and 01", bad_mem, idx, mem[idx]); end
        model_reset();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0;
        pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 2'($urandom_range(0, 3));
        sram_dout = 2'($urandom_range(0, 3));
        model_reset();
        $display("[TB] starting gshare_pht_ctrl bench");
        test_reset();
        test_init_sweep();
        test_predict_basic();
        test_update_saturate();
        test_not_taken();
        test_back_to_back();
        test_random_traffic();
        test_reset_mid_update();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
